ddr2_cmd_scheduler: RTL and testbench

//  Post-init DDR2 command sequencer. Pops 33-bit entries from the command FIFO and runs a

---
 rtl/ddr2_cmd_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ddr2_cmd_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_scheduler
// Post-init DDR2 command sequencer. Pops one 33-bit entry at a time from the
// command FIFO and runs a closed-page sequence for it: ACT, posted READ/WRITE
// with auto-precharge (A10=1), then a wait that enforces the ACT-to-ACT
// spacing. Burst data is moved between the input-data FIFO, the SSTL18 pad
// interface and the return FIFO.
//
// Optional feature: define DDR2_REFRESH_EN to enable the periodic AUTO
// REFRESH generator (one REF every 1560 clk, serviced from IDLE ahead of the
// command FIFO, followed by a 52 clk tRFC wait).
//
// Ports
//   clk, reset      system clock (ck = clk/2); synchronous active-high reset
//   ready           init engine done; scheduler stays idle while low
//   ck              current ck phase; new sequences launch only when ck==1
//   cmd_notempty    command FIFO not empty
//   cmd_data        [32:30] cmd (001 READ, 010 WRITE, else discard), [24:0] addr
//   cmd_get         one-clk pop of the command FIFO
//   in_fillcount    input-data FIFO occupancy
//   in_data         input-data FIFO head
//   in_get          input-data FIFO pop
//   ret_fillcount   return FIFO occupancy
//   ret_put         return FIFO push
//   ret_data        {addr[24:3], beat[2:0], dq_o}
//   csbar..webar    DRAM command
//   ba, a           bank address / row or column address
//   dq_i            write data to pads
//   dqs_i, dqsbar_i write strobes
//   dm_i            data mask (always 0)
//   ts_i            pad output enable (preamble + 8 beats)
//   ri_i            pad receive enable (low while driving)
//   dq_o            read data from pads
// ---------------------------------------------------------------------------
module ddr2_cmd_scheduler #(
   parameter int AL          = 3,
   parameter int CL          = 4,
   parameter int BL          = 8,
   parameter int T_RCD_CK    = 1,
   parameter int T_CYCLE_CLK = 40,
   parameter int RET_ROOM    = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready,
   input  logic        ck,
   input  logic        cmd_notempty,
   input  logic [32:0] cmd_data,
   output logic        cmd_get,
   input  logic [5:0]  in_fillcount,
   input  logic [15:0] in_data,
   output logic        in_get,
   input  logic [5:0]  ret_fillcount,
   output logic        ret_put,
   output logic [40:0] ret_data,
   output logic        csbar,
   output logic        rasbar,
   output logic        casbar,
   output logic        webar,
   output logic [1:0]  ba,
   output logic [12:0] a,
   output logic [15:0] dq_i,
   output logic [1:0]  dqs_i,
   output logic [1:0]  dqsbar_i,
   output logic [1:0]  dm_i,
   output logic        ts_i,
   output logic        ri_i,
   input  logic [15:0] dq_o
);

   localparam int WL = AL + CL - 1;

   // All timing is measured in clk cycles from the first ACT cycle (cnt==0).
   localparam logic [7:0] T_CAS     = 8'(2 * T_RCD_CK);
   localparam logic [7:0] T_RD      = 8'(2 * T_RCD_CK + 2 * (AL + CL));
   localparam logic [7:0] T_RD_END  = T_RD + 8'(BL - 1);
   localparam logic [7:0] T_WR      = 8'(2 * T_RCD_CK + 2 * WL);
   localparam logic [7:0] T_WR_END  = T_WR + 8'(BL - 1);
   // IDLE is entered one clk early so that the pop decided there launches
   // the next ACT exactly T_CYCLE_CLK after the previous one.
   localparam logic [7:0] T_RELEASE = 8'(T_CYCLE_CLK - 2);
   localparam logic [7:0] T_RFC_END = 8'(2 + 52 - 2);
   localparam logic [5:0] RET_LIM   = 6'(RET_ROOM);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACT,
      S_WAIT_RCD,
      S_CAS,
      S_DATA,
      S_WAIT_CYC,
      S_REF,
      S_WAIT_RFC
   } state_t;

   state_t      state, state_n;
   logic [7:0]  cnt;
   logic [24:0] addr_q;
   logic        is_wr;
   logic [2:0]  beat;

   logic        unused_bits;
   assign unused_bits = ^cmd_data[29:25];

`ifdef DDR2_REFRESH_EN
   logic [10:0] ref_cnt;
   logic        ref_pend;
   logic        launch_ref;
`endif

   // ------------------------------------------------------------------
   // State, sequence counter and latched command
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         addr_q <= '0;
         is_wr  <= 1'b0;
      end else begin
         state <= state_n;
         if (state == S_IDLE)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + 8'd1;
         if (state == S_IDLE && state_n == S_ACT) begin
            addr_q <= cmd_data[24:0];
            is_wr  <= cmd_data[31];
         end
      end
   end

`ifdef DDR2_REFRESH_EN
   // Request counter saturates at the request point and holds the pending
   // flag until IDLE launches the REF, which restarts the interval.
   always_ff @(posedge clk) begin
      if (reset) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
      end else if (launch_ref) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
      end else if (ready) begin
         if (ref_cnt >= 11'd1559)
            ref_pend <= 1'b1;
         else
            ref_cnt <= ref_cnt + 11'd1;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Next state and FIFO pop
   // ------------------------------------------------------------------
   always_comb begin
      state_n = state;
      cmd_get = 1'b0;
`ifdef DDR2_REFRESH_EN
      launch_ref = 1'b0;
`endif
      if (!reset) begin
         case (state)
            S_IDLE: begin
               if (ready && ck) begin
`ifdef DDR2_REFRESH_EN
                  if (ref_pend) begin
                     launch_ref = 1'b1;
                     state_n    = S_REF;
                  end else
`endif
                  if (cmd_notempty) begin
                     case (cmd_data[32:30])
                        3'b001: if (ret_fillcount <= RET_LIM) begin
                           cmd_get = 1'b1;
                           state_n = S_ACT;
                        end
                        3'b010: if (in_fillcount >= 6'd8) begin
                           cmd_get = 1'b1;
                           state_n = S_ACT;
                        end
                        default: cmd_get = 1'b1;
                     endcase
                  end
               end
            end
            S_ACT:      if (cnt == 8'd1) state_n = (T_RCD_CK > 1) ? S_WAIT_RCD : S_CAS;
            S_WAIT_RCD: if (cnt == T_CAS - 8'd1) state_n = S_CAS;
            S_CAS:      if (cnt == T_CAS + 8'd1) state_n = S_DATA;
            S_DATA: begin
               if (is_wr ? (cnt == T_WR_END) : (cnt == T_RD_END))
                  state_n = S_WAIT_CYC;
            end
            S_WAIT_CYC: if (cnt >= T_RELEASE) state_n = S_IDLE;
            S_REF:      if (cnt == 8'd1) state_n = S_WAIT_RFC;
            S_WAIT_RFC: if (cnt >= T_RFC_END) state_n = S_IDLE;
            default:    state_n = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // DRAM command, pad and FIFO data outputs
   // ------------------------------------------------------------------
   always_comb begin
      csbar    = 1'b0;
      rasbar   = 1'b1;
      casbar   = 1'b1;
      webar    = 1'b1;
      a        = '0;
      ba       = '0;
      ret_put  = 1'b0;
      ret_data = '0;
      in_get   = 1'b0;
      dq_i     = '0;
      dqs_i    = '0;
      dqsbar_i = '1;
      dm_i     = '0;
      ts_i     = 1'b0;
      ri_i     = 1'b1;
      beat     = is_wr ? 3'(cnt - T_WR) : 3'(cnt - T_RD);
      if (!reset) begin
         case (state)
            S_ACT: begin
               rasbar = 1'b0;
               a      = addr_q[24:12];
               ba     = addr_q[11:10];
            end
            S_CAS: begin
               casbar = 1'b0;
               webar  = ~is_wr;
               a      = {2'b00, 1'b1, addr_q[9:0]};
               ba     = addr_q[11:10];
            end
            S_DATA: begin
               if (!is_wr) begin
                  if (cnt >= T_RD && cnt <= T_RD_END) begin
                     ret_put  = 1'b1;
                     ret_data = {addr_q[24:3], beat, dq_o};
                  end
               end else begin
                  // Output enable opens one clk early for the DQS preamble.
                  if (cnt >= T_WR - 8'd1 && cnt <= T_WR_END) begin
                     ts_i = 1'b1;
                     ri_i = 1'b0;
                  end
                  if (cnt >= T_WR && cnt <= T_WR_END) begin
                     in_get   = 1'b1;
                     dq_i     = in_data;
                     dqs_i    = {2{~beat[0]}};
                     dqsbar_i = {2{beat[0]}};
                  end
               end
            end
            S_REF: begin
               rasbar = 1'b0;
               casbar = 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ddr2_cmd_scheduler
// Directed bench for ddr2_cmd_scheduler (default build, refresh disabled).
// A background process models the command FIFO, drives ck and the data
// sources, and logs every DUT output once per clk at the falling edge. The
// main sequence issues directed commands and checks the logged cycles
// against hand-computed timings and values.
// ---------------------------------------------------------------------------
module tb_ddr2_cmd_scheduler;

   localparam logic [3:0] C_NOP   = 4'b0111;
   localparam logic [3:0] C_ACT   = 4'b0011;
   localparam logic [3:0] C_READ  = 4'b0101;
   localparam logic [3:0] C_WRITE = 4'b0100;
   localparam logic [3:0] C_REF   = 4'b0001;
   localparam int         LOGN    = 4096;

   // {a, ba, cs/ras/cas/we, ts, ri, dqs, dqsbar, dm, ret_put, in_get, cmd_get}
   localparam logic [29:0] EXP_IDLE = {13'd0, 2'd0, 4'b0111, 1'b0, 1'b1,
                                       2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        reset, ready, ck, cmd_notempty;
   logic [32:0] cmd_data;
   logic        cmd_get;
   logic [5:0]  in_fillcount, ret_fillcount;
   logic [15:0] in_data, dq_o;
   logic        in_get, ret_put;
   logic [40:0] ret_data;
   logic        csbar, rasbar, casbar, webar;
   logic [1:0]  ba;
   logic [12:0] a;
   logic [15:0] dq_i;
   logic [1:0]  dqs_i, dqsbar_i, dm_i;
   logic        ts_i, ri_i;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [12:0] a;
      logic [1:0]  ba;
      logic        rp;
      logic [40:0] rd;
      logic        ig;
      logic        ts;
      logic        ri;
      logic [15:0] dqi;
      logic [1:0]  dqs;
      logic [1:0]  dqsb;
      logic        cg;
   } rec_t;

   rec_t        lg [LOGN];
   logic [32:0] q [$];
   int          cyc;
   logic        pop_req;
   int          n_pass  = 0;
   int          n_total = 0;

   ddr2_cmd_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .ready         (ready),
      .ck            (ck),
      .cmd_notempty  (cmd_notempty),
      .cmd_data      (cmd_data),
      .cmd_get       (cmd_get),
      .in_fillcount  (in_fillcount),
      .in_data       (in_data),
      .in_get        (in_get),
      .ret_fillcount (ret_fillcount),
      .ret_put       (ret_put),
      .ret_data      (ret_data),
      .csbar         (csbar),
      .rasbar        (rasbar),
      .casbar        (casbar),
      .webar         (webar),
      .ba            (ba),
      .a             (a),
      .dq_i          (dq_i),
      .dqs_i         (dqs_i),
      .dqsbar_i      (dqsbar_i),
      .dm_i          (dm_i),
      .ts_i          (ts_i),
      .ri_i          (ri_i),
      .dq_o          (dq_o)
   );

   always #5 clk = ~clk;

   // FIFO model, ck phase, data sources and per-cycle output log.
   initial begin
      rec_t r;
      cyc          = 0;
      ck           = 1'b0;
      pop_req      = 1'b0;
      cmd_notempty = 1'b0;
      cmd_data     = '0;
      dq_o         = 16'hD000;
      in_data      = 16'hB000;
      forever begin
         @(negedge clk);
         r.cmd  = {csbar, rasbar, casbar, webar};
         r.a    = a;
         r.ba   = ba;
         r.rp   = ret_put;
         r.rd   = ret_data;
         r.ig   = in_get;
         r.ts   = ts_i;
         r.ri   = ri_i;
         r.dqi  = dq_i;
         r.dqs  = dqs_i;
         r.dqsb = dqsbar_i;
         r.cg   = cmd_get;
         if (cyc < LOGN) lg[cyc] = r;
         pop_req = cmd_get;
         @(posedge clk);
         #1;
         cyc = cyc + 1;
         ck  = ~ck;
         if (pop_req && q.size() > 0) void'(q.pop_front());
         cmd_notempty = (q.size() > 0);
         cmd_data     = (q.size() > 0) ? q[0] : '0;
         dq_o         = 16'hD000 + 16'(cyc);
         in_data      = 16'hB000 + 16'(cyc);
      end
   end

   function automatic rec_t at(input int c);
      if (c >= 0 && c < LOGN) return lg[c];
      return '0;
   endfunction

   function automatic int first_code(input int from, input int n, input logic [3:0] code);
      for (int c = from; c < from + n; c++)
         if (at(c).cmd === code) return c;
      return -1;
   endfunction

   function automatic int count_code(input int from, input int n, input logic [3:0] code);
      int k = 0;
      for (int c = from; c < from + n; c++)
         if (at(c).cmd === code) k++;
      return k;
   endfunction

   // sel: 0 ret_put, 1 in_get, 2 ts_i, 3 cmd_get
   function automatic int cnt_bit(input int from, input int n, input int sel);
      int   k = 0;
      rec_t r;
      for (int c = from; c < from + n; c++) begin
         r = at(c);
         case (sel)
            0:       if (r.rp === 1'b1) k++;
            1:       if (r.ig === 1'b1) k++;
            2:       if (r.ts === 1'b1) k++;
            default: if (r.cg === 1'b1) k++;
         endcase
      end
      return k;
   endfunction

   function automatic logic [29:0] outvec();
      return {a, ba, csbar, rasbar, casbar, webar, ts_i, ri_i,
              dqs_i, dqsbar_i, dm_i, ret_put, in_get, cmd_get};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int s, t1, t2, tc, exp_t, r0;
      logic found;

      reset         = 1'b1;
      ready         = 1'b0;
      in_fillcount  = '0;
      ret_fillcount = '0;

      // Reset and not-ready: NOP only, no pop even with a command queued.
      q.push_back({3'b001, 5'd0, 25'h1ABCDEF});
      step(3);
      chk("rst_outputs", outvec(), EXP_IDLE);
      step(3);
      reset = 1'b0;
      step(10);
      chk("noready_outputs", outvec(), EXP_IDLE);
      chk("noready_nop", count_code(0, cyc, C_NOP), cyc);
      chk("noready_noget", cnt_bit(0, cyc, 3), 0);
      chk("noready_queue", q.size(), 1);

      // READ 0x1ABCDEF.
      ready = 1'b1;
      s = cyc;
      step(60);
      t1 = first_code(s, 10, C_ACT);
      chk("rd_act_seen", t1 >= 0, 1);
      if (t1 < 0) t1 = 0;
      chk("rd_act_addr", {at(t1).ba, at(t1).a}, {2'd3, 13'h1ABC});
      chk("rd_act_hold", {at(t1 + 1).cmd, at(t1 + 2).cmd}, {C_ACT, C_READ});
      chk("rd_cas_seq", {at(t1 + 3).cmd, at(t1 + 4).cmd}, {C_READ, C_NOP});
      chk("rd_cas_addr", {at(t1 + 2).ba, at(t1 + 2).a}, {2'd3, 13'h5EF});
      chk("rd_put_count", cnt_bit(t1, 40, 0), 8);
      chk("rd_put_edges", {at(t1 + 15).rp, at(t1 + 16).rp, at(t1 + 23).rp, at(t1 + 24).rp}, 4'b0110);
      for (int k = 0; k < 8; k++)
         chk($sformatf("rd_data_b%0d", k), at(t1 + 16 + k).rd,
             {22'h3579BD, 3'(k), 16'(16'hD000 + t1 + 16 + k)});
      chk("rd_get_count", cnt_bit(s, 60, 3), 1);

      // WRITE stalls at in_fillcount=7, launches one ck edge after 8.
      in_fillcount = 6'd7;
      q.push_back({3'b010, 5'd0, 25'h0123456});
      s = cyc;
      step(20);
      chk("wr_stall_get", cnt_bit(s, 20, 3), 0);
      chk("wr_stall_act", count_code(s, 20, C_ACT), 0);
      in_fillcount = 6'd8;
      s = cyc;
      exp_t = ck ? s + 1 : s + 2;
      step(60);
      t1 = first_code(s, 10, C_ACT);
      chk("wr_act_time", t1, exp_t);
      if (t1 < 0) t1 = 0;
      tc = t1 + 2;
      chk("wr_act_addr", {at(t1).ba, at(t1).a}, {2'd1, 13'h123});
      chk("wr_cas", {at(tc).cmd, at(tc).ba, at(tc).a}, {C_WRITE, 2'd1, 13'h456});
      chk("wr_get_count", cnt_bit(t1, 40, 1), 8);
      chk("wr_get_edges", {at(tc + 11).ig, at(tc + 12).ig, at(tc + 19).ig, at(tc + 20).ig}, 4'b0110);
      chk("wr_ts_count", cnt_bit(t1, 40, 2), 9);
      chk("wr_ts_edges", {at(tc + 10).ts, at(tc + 11).ts, at(tc + 19).ts, at(tc + 20).ts}, 4'b0110);
      chk("wr_ri", {at(tc + 10).ri, at(tc + 11).ri, at(tc + 15).ri, at(tc + 20).ri}, 4'b1001);
      chk("wr_dq_b0", at(tc + 12).dqi, 16'(16'hB000 + tc + 12));
      chk("wr_dq_b7", at(tc + 19).dqi, 16'(16'hB000 + tc + 19));
      chk("wr_dqs", {at(tc + 11).dqs, at(tc + 12).dqs, at(tc + 13).dqs, at(tc + 14).dqs,
                     at(tc + 12).dqsb, at(tc + 13).dqsb},
          {2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11});

      // READ stalls at ret_fillcount=25, launches at 24.
      ret_fillcount = 6'd25;
      q.push_back({3'b001, 5'd0, 25'h0000808});
      s = cyc;
      step(20);
      chk("rd_room_stall", cnt_bit(s, 20, 3), 0);
      ret_fillcount = 6'd24;
      s = cyc;
      exp_t = ck ? s + 1 : s + 2;
      step(50);
      t1 = first_code(s, 10, C_ACT);
      chk("rd_room_act_time", t1, exp_t);
      chk("rd_room_cas", {at(t1 + 2).cmd, at(t1 + 2).ba, at(t1 + 2).a}, {C_READ, 2'd2, 13'h408});
      ret_fillcount = '0;

      // Discard code 111, then two back-to-back READs.
      q.push_back({3'b111, 5'd0, 25'h1FFFFFF});
      q.push_back({3'b001, 5'd0, 25'h0002000});
      q.push_back({3'b001, 5'd0, 25'h0004C00});
      s = cyc;
      step(100);
      t1 = first_code(s, 15, C_ACT);
      if (t1 < 0) t1 = s;
      t2 = first_code(t1 + 2, 60, C_ACT);
      chk("b2b_spacing", t2 - t1, 40);
      chk("b2b_rows", {at(t1).a, at(t2).a, at(t2).ba}, {13'd2, 13'd4, 2'd3});
      chk("b2b_gets", cnt_bit(s, 100, 3), 3);
      chk("b2b_queue", q.size(), 0);
      chk("b2b_act_cycles", count_code(s, 100, C_ACT), 4);
      chk("b2b_puts", cnt_bit(s, 100, 0), 16);

      // Reset mid-sequence: popped entry is lost, nothing further happens.
      q.push_back({3'b001, 5'd0, 25'h0010000});
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         if (rasbar === 1'b0 && casbar === 1'b1) found = 1'b1;
      end
      chk("midrst_act_seen", found, 1'b1);
      step(4);
      reset = 1'b1;
      r0 = cyc;
      step(1);
      chk("midrst_outputs", outvec(), EXP_IDLE);
      step(1);
      reset = 1'b0;
      step(40);
      chk("midrst_no_put", cnt_bit(r0, 42, 0), 0);
      chk("midrst_no_act", count_code(r0, 42, C_ACT), 0);

      // Long idle with ready=1: refresh is not built in.
      step(1700);
      chk("final_idle", outvec(), EXP_IDLE);
      chk("no_ref", count_code(0, cyc, C_REF), 0);
      chk("total_act_cycles", count_code(0, cyc, C_ACT), 12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
